// File: rtl/fir_output_formatter_if.sv
// fir_output_formatter_if: FIR result input and formatted valid/ready output stream
interface fir_output_formatter_if #(
  parameter int IN_WIDTH  = 38,
  parameter int OUT_WIDTH = 16
);
  logic signed [IN_WIDTH-1:0] fir_output;
  logic                       output_valid;
  logic [OUT_WIDTH-1:0]       m_data;
  logic                       m_valid;
  logic                       m_ready;
  modport master (input fir_output, output_valid, m_ready, output m_data, m_valid);
  modport slave  (output fir_output, output_valid, m_ready, input m_data, m_valid);
endinterface

// File: rtl/fir_output_formatter.sv
// fir_output_formatter: rounds, scales and saturates FIR results into a FIFO-backed valid/ready stream
module fir_output_formatter #(
  parameter int WIDTH     = 16,
  parameter int IN_WIDTH  = 2*WIDTH+6,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
)(
  input  logic                   clk,
  input  logic                   rst,
  fir_output_formatter_if.master io,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   sat_flag,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   sat_count,
  output logic [CNT_WIDTH-1:0]   drop_count,
  input  logic                   clear_stats
);
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [IN_WIDTH:0] ROUND = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT-1);
  localparam logic signed [IN_WIDTH:0] MAX_V = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] MIN_V = {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  logic                       prev_valid, s1_valid, s2_valid, capture;
  logic signed [IN_WIDTH-1:0] s1_data;
  logic signed [IN_WIDTH:0]   s2_data, rounded;
  logic [OUT_WIDTH-1:0]       mem [DEPTH];
  logic [AW:0]                wr_ptr, rd_ptr;
  logic                       sat_hi, sat_lo, sat, full, pop, push, drop;
  logic [OUT_WIDTH-1:0]       clamped;
  always_comb begin
    capture    = io.output_valid && !prev_valid;
    rounded    = ($signed({s1_data[IN_WIDTH-1], s1_data}) + ROUND) >>> SHIFT;
    sat_hi     = s2_data > MAX_V;
    sat_lo     = s2_data < MIN_V;
    sat        = s2_valid && (sat_hi || sat_lo);
    clamped    = sat_hi ? MAX_V[OUT_WIDTH-1:0] : sat_lo ? MIN_V[OUT_WIDTH-1:0] : s2_data[OUT_WIDTH-1:0];
    fifo_level = wr_ptr - rd_ptr;
    full       = fifo_level == (AW+1)'(DEPTH);
    io.m_valid = fifo_level != '0;
    io.m_data  = io.m_valid ? mem[rd_ptr[AW-1:0]] : '0;
    pop        = io.m_valid && io.m_ready;
    push       = s2_valid && (!full || pop);
    drop       = s2_valid && full && !pop;
  end
  always_ff @(posedge clk) begin
    if (capture) s1_data <= io.fir_output;
    s2_data <= rounded;
    if (push) mem[wr_ptr[AW-1:0]] <= clamped;
  end
  // an event coinciding with clear_stats survives the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sat_flag   <= 1'b0;
      overflow   <= 1'b0;
      sat_count  <= '0;
      drop_count <= '0;
    end else begin
      prev_valid <= io.output_valid;
      s1_valid   <= capture;
      s2_valid   <= s1_valid;
      wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
      sat_flag   <= (sat_flag && !clear_stats) || sat;
      overflow   <= (overflow && !clear_stats) || drop;
      sat_count  <= clear_stats ? CNT_WIDTH'(sat) : (sat && ~&sat_count) ? sat_count + 1'b1 : sat_count;
      drop_count <= clear_stats ? CNT_WIDTH'(drop) : (drop && ~&drop_count) ? drop_count + 1'b1 : drop_count;
    end
  end
endmodule

// File: tb/tb_fir_output_formatter.sv
// tb_fir_output_formatter: directed vectors with a scoreboard queue checked by an independent output monitor
module tb_fir_output_formatter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_stats = 1'b0;
  logic [3:0]  fifo_level;
  logic        sat_flag, overflow;
  logic [15:0] sat_count, drop_count;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q [$];

  fir_output_formatter_if #(.IN_WIDTH(38), .OUT_WIDTH(16)) io ();

  fir_output_formatter dut (
    .clk(clk), .rst(rst), .io(io), .fifo_level(fifo_level), .sat_flag(sat_flag),
    .overflow(overflow), .sat_count(sat_count), .drop_count(drop_count), .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic signed [37:0] v, input logic [15:0] e, input bit keep = 1'b1);
    io.fir_output = v;
    io.output_valid = 1'b1;
    if (keep) exp_q.push_back(e);
    tick();
    io.output_valid = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst && io.m_valid && io.m_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: unexpected m_data %0h", io.m_data);
      end else check("m_data", 64'(io.m_data), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    io.fir_output = '0;
    io.output_valid = 1'b0;
    io.m_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    check("reset m_valid", 64'(io.m_valid), 0);
    check("reset level", 64'(fifo_level), 0);
    check("reset sat_count", 64'(sat_count), 0);
    check("reset drop_count", 64'(drop_count), 0);
    check("reset flags", 64'({sat_flag, overflow}), 0);
    // latency: edge-to-m_valid is 3 cycles
    io.m_ready = 1'b1;
    io.fir_output = 38'sd16384;
    io.output_valid = 1'b1;
    exp_q.push_back(16'h0001);
    tick();
    io.output_valid = 1'b0;
    check("lat T+1 m_valid", 64'(io.m_valid), 0);
    tick();
    check("lat T+2 m_valid", 64'(io.m_valid), 0);
    tick();
    check("lat T+3 m_valid", 64'(io.m_valid), 1);
    check("lat T+3 level", 64'(fifo_level), 1);
    tick();
    check("lat T+4 m_valid", 64'(io.m_valid), 0);
    check("lat T+4 level", 64'(fifo_level), 0);
    // rounding
    capture(38'sd16384, 16'h0001);
    capture(38'sd16383, 16'h0000);
    capture(-38'sd16384, 16'h0000);
    capture(-38'sd16385, 16'hFFFF);
    tick(4);
    // saturation
    capture(38'sd2147483648, 16'h7FFF);
    tick(3);
    check("sat flag", 64'(sat_flag), 1);
    check("sat count 1", 64'(sat_count), 1);
    capture(-38'sd2147483648, 16'h8000);
    tick(3);
    check("sat count 2", 64'(sat_count), 2);
    io.fir_output = 38'sd2147483648;
    io.output_valid = 1'b1;
    exp_q.push_back(16'h7FFF);
    tick();
    io.output_valid = 1'b0;
    tick();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("clear+event count", 64'(sat_count), 1);
    check("clear+event flag", 64'(sat_flag), 1);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("clear count", 64'(sat_count), 0);
    check("clear flag", 64'(sat_flag), 0);
    tick(2);
    // full FIFO: ninth sample dropped
    io.m_ready = 1'b0;
    for (int i = 0; i < 9; i++) capture(38'(i + 1) <<< 15, 16'(i + 1), i < 8);
    tick(3);
    check("full level", 64'(fifo_level), 8);
    check("drop count", 64'(drop_count), 1);
    check("overflow", 64'(overflow), 1);
    check("head stable", 64'(io.m_data), 1);
    io.m_ready = 1'b1;
    tick(10);
    check("drained level", 64'(fifo_level), 0);
    // held level gives one capture per rising edge
    io.m_ready = 1'b0;
    io.fir_output = 38'sd3 <<< 15;
    io.output_valid = 1'b1;
    exp_q.push_back(16'd3);
    tick(5);
    io.output_valid = 1'b0;
    tick(4);
    check("held level one", 64'(fifo_level), 1);
    tick();
    io.fir_output = 38'sd5 <<< 15;
    io.output_valid = 1'b1;
    exp_q.push_back(16'd5);
    tick(3);
    io.output_valid = 1'b0;
    tick(2);
    check("held level two", 64'(fifo_level), 2);
    io.m_ready = 1'b1;
    tick(4);
    check("held drained", 64'(fifo_level), 0);
    // reset mid-operation, with output_valid already high on release
    io.m_ready = 1'b0;
    capture(38'sd7 <<< 15, 16'd7);
    capture(38'sd2147483648, 16'h7FFF);
    capture(38'sd9 <<< 15, 16'd9);
    tick(3);
    check("pre-reset level", 64'(fifo_level), 3);
    check("pre-reset sat", 64'(sat_count), 1);
    rst = 1'b1;
    exp_q.delete();
    io.fir_output = 38'sd2 <<< 15;
    io.output_valid = 1'b1;
    tick();
    rst = 1'b0;
    check("post-reset m_valid", 64'(io.m_valid), 0);
    check("post-reset level", 64'(fifo_level), 0);
    check("post-reset counts", 64'({sat_count, drop_count}), 0);
    check("post-reset flags", 64'({sat_flag, overflow}), 0);
    exp_q.push_back(16'd2);
    tick();
    io.output_valid = 1'b0;
    tick(2);
    check("first-cycle edge", 64'(fifo_level), 1);
    io.m_ready = 1'b1;
    tick(3);
    check("scoreboard empty", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
